// File: rtl/div_seq.sv
// Multi-cycle radix-2 restoring divider for RISC-V DIV/DIVU/REM/REMU.
// Result packing is {remainder, quotient}; one quotient bit is produced per cycle.
module div_seq #(
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                signed_div_i,
    input  logic [DATA_W-1:0]   opdata1_i,
    input  logic [DATA_W-1:0]   opdata2_i,
    input  logic                start_i,
    input  logic                annul_i,
    output logic [2*DATA_W-1:0] result_o,
    output logic                ready_o
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

    function automatic logic [DATA_W-1:0] neg_if(input logic [DATA_W-1:0] v, input logic en);
        return en ? (~v + DATA_W'(1)) : v;
    endfunction

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  ready_q, ready_d;
    logic [2*DATA_W-1:0]   result_q, result_d;

    logic [2*DATA_W:0]     part_q, part_d;
    logic [DATA_W-1:0]     divisor_q, divisor_d;
    logic [DATA_W-1:0]     dividend_q, dividend_d;
    logic                  neg_quot_q, neg_quot_d;
    logic                  neg_rem_q, neg_rem_d;
    logic [2*DATA_W-1:0]   res_q, res_d;

    logic signed [DATA_W-1:0] op1_s, op2_s;
    logic                     op1_neg, op2_neg;

    logic [2*DATA_W+1:0]   shift;
    logic [DATA_W+1:0]     upper;
    logic [DATA_W:0]       diff;
    logic                  geq;
    logic [2*DATA_W:0]     step;

    assign op1_s   = opdata1_i;
    assign op2_s   = opdata2_i;
    assign op1_neg = signed_div_i && (op1_s < 0);
    assign op2_neg = signed_div_i && (op2_s < 0);

    // One restoring step; the top bit of upper is always zero in practice but keeps the compare exact.
    always_comb begin
        shift = {part_q, 1'b0};
        upper = shift[2*DATA_W+1:DATA_W];
        diff  = upper[DATA_W:0] - {1'b0, divisor_q};
        geq   = upper[DATA_W+1] || (upper[DATA_W:0] >= {1'b0, divisor_q});
        step  = geq ? {diff, shift[DATA_W-1:1], 1'b1} : shift[2*DATA_W:0];
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ready_d    = 1'b0;
        result_d   = '0;
        part_d     = part_q;
        divisor_d  = divisor_q;
        dividend_d = dividend_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        res_d      = res_q;

        case (state_q)
            FREE: begin
                if (start_i && !annul_i) begin
                    dividend_d = opdata1_i;
                    if (opdata2_i == '0) begin
                        state_d = BYZERO;
                    end else begin
                        divisor_d  = neg_if(opdata2_i, op2_neg);
                        part_d     = {{(DATA_W+1){1'b0}}, neg_if(opdata1_i, op1_neg)};
                        neg_quot_d = op1_neg ^ op2_neg;
                        neg_rem_d  = op1_neg;
                        cnt_d      = '0;
                        state_d    = ON;
                    end
                end
            end

            BYZERO: begin
                if (annul_i || !start_i) begin
                    state_d = FREE;
                end else begin
                    res_d   = {dividend_q, {DATA_W{1'b1}}};
                    state_d = END;
                end
            end

            ON: begin
                if (annul_i || !start_i) begin
                    cnt_d   = '0;
                    state_d = FREE;
                end else begin
                    part_d = step;
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(DATA_W-1)) begin
                        res_d   = {neg_if(step[2*DATA_W-1:DATA_W], neg_rem_q),
                                   neg_if(step[DATA_W-1:0], neg_quot_q)};
                        cnt_d   = '0;
                        state_d = END;
                    end
                end
            end

            END: begin
                if (annul_i || !start_i) begin
                    state_d = FREE;
                end else begin
                    ready_d  = 1'b1;
                    result_d = res_q;
                end
            end

            default: state_d = FREE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= FREE;
            cnt_q    <= '0;
            ready_q  <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ready_q  <= ready_d;
            result_q <= result_d;
        end
    end

    // Datapath registers carry no reset; the FSM never reads them before loading.
    always_ff @(posedge clk) begin
        part_q     <= part_d;
        divisor_q  <= divisor_d;
        dividend_q <= dividend_d;
        neg_quot_q <= neg_quot_d;
        neg_rem_q  <= neg_rem_d;
        res_q      <= res_d;
    end

    assign ready_o  = ready_q;
    assign result_o = result_q;

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: scoreboard of expected {rem, quo} values,
// latency checks, abort, annul priority and reset paths.
module tb_div_seq;

    localparam int DATA_W = 32;

    logic        clk;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    int checks = 0;
    int errors = 0;
    logic [63:0] sb_q[$];

    div_seq #(.DATA_W(DATA_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference built on the language's own division operators.
    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic [31:0] q;
        logic [31:0] r;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (s) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                q = 32'h8000_0000;
                r = 32'd0;
            end else begin
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
            end
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    // Issue one request, hold start until ready, optionally keep holding, then release.
    task automatic run_req(input logic [31:0] a, input logic [31:0] b, input logic s,
                           input logic [63:0] exp, input int hold, input string name);
        int          lat;
        int          want_lat;
        bit          got;
        logic [63:0] want;
        want_lat     = (b == 32'd0) ? 2 : 33;
        opdata1_i    = a;
        opdata2_i    = b;
        signed_div_i = s;
        annul_i      = 1'b0;
        start_i      = 1'b1;
        sb_q.push_back(exp);
        got = 0;
        lat = -1;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk); #1;
            if (ready_o) begin
                got = 1;
                lat = k;
                break;
            end
            opdata1_i    = $urandom;
            opdata2_i    = $urandom;
            signed_div_i = 1'($urandom_range(0, 1));
        end
        checks++;
        if (!got || lat != want_lat) begin
            errors++;
            $display("FAIL %s latency: got %0d cycles, expected %0d", name, lat, want_lat);
        end
        want = sb_q.pop_front();
        checks++;
        if (result_o !== want) begin
            errors++;
            $display("FAIL %s result: got %h, expected %h", name, result_o, want);
        end
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            checks++;
            if (ready_o !== 1'b1 || result_o !== want) begin
                errors++;
                $display("FAIL %s hold: ready=%b result=%h, expected ready=1 result=%h",
                         name, ready_o, result_o, want);
            end
        end
        start_i = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (ready_o !== 1'b0 || result_o !== 64'd0) begin
            errors++;
            $display("FAIL %s release: ready=%b result=%h, expected ready=0 result=0",
                     name, ready_o, result_o);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        signed_div_i = 1'b0;
        opdata1_i    = 32'd0;
        opdata2_i    = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (ready_o !== 1'b0 || result_o !== 64'd0) begin
            errors++;
            $display("FAIL reset_state: ready=%b result=%h, expected ready=0 result=0",
                     ready_o, result_o);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_unsigned();
        run_req(32'd100, 32'd7, 1'b0, 64'h00000002_0000000E, 2, "udiv_100_7");
        run_req(32'hFFFF_FFFF, 32'd1, 1'b0, 64'h00000000_FFFFFFFF, 0, "udiv_max_1");
    endtask

    task automatic test_signed();
        run_req(32'hFFFF_FFF9, 32'd2, 1'b1, 64'hFFFFFFFF_FFFFFFFD, 0, "sdiv_m7_2");
        run_req(32'd7, 32'hFFFF_FFFE, 1'b1, 64'h00000001_FFFFFFFD, 0, "sdiv_7_m2");
    endtask

    task automatic test_div_zero();
        run_req(32'd5, 32'd0, 1'b1, 64'h00000005_FFFFFFFF, 1, "div0_signed");
        run_req(32'd5, 32'd0, 1'b0, 64'h00000005_FFFFFFFF, 0, "div0_unsigned");
    endtask

    task automatic test_overflow();
        run_req(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 64'h00000000_80000000, 0, "sdiv_overflow");
    endtask

    // Abort at T+10 either by annul (held with start high) or by dropping start.
    task automatic test_abort(input bit use_annul, input string name);
        bit seen;
        opdata1_i    = 32'd100;
        opdata2_i    = 32'd7;
        signed_div_i = 1'b0;
        annul_i      = 1'b0;
        start_i      = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
        end
        if (use_annul) annul_i = 1'b1;
        else           start_i = 1'b0;
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (ready_o) seen = 1;
        end
        checks++;
        if (seen || result_o !== 64'd0) begin
            errors++;
            $display("FAIL %s: ready_seen=%0d result=%h, expected ready_seen=0 result=0",
                     name, seen, result_o);
        end
        annul_i = 1'b0;
        start_i = 1'b0;
        @(posedge clk); #1;
        run_req(32'd9, 32'd3, 1'b0, 64'h00000000_00000003, 0, {name, "_follow"});
    endtask

    task automatic test_reset_mid();
        bit got;
        opdata1_i    = 32'd100;
        opdata2_i    = 32'd7;
        signed_div_i = 1'b0;
        annul_i      = 1'b0;
        start_i      = 1'b1;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (ready_o !== 1'b0 || result_o !== 64'd0) begin
            errors++;
            $display("FAIL reset_mid_on: ready=%b result=%h, expected ready=0 result=0",
                     ready_o, result_o);
        end
        rst     = 1'b0;
        start_i = 1'b0;
        @(posedge clk); #1;
        // Reset while the result is being presented.
        opdata1_i = 32'd50;
        opdata2_i = 32'd5;
        start_i   = 1'b1;
        got = 0;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk); #1;
            if (ready_o) begin
                got = 1;
                break;
            end
        end
        checks++;
        if (!got || result_o !== 64'h00000000_0000000A) begin
            errors++;
            $display("FAIL reset_end_setup: ready=%b result=%h, expected ready=1 result=%h",
                     ready_o, result_o, 64'h00000000_0000000A);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (ready_o !== 1'b0 || result_o !== 64'd0) begin
            errors++;
            $display("FAIL reset_in_end: ready=%b result=%h, expected ready=0 result=0",
                     ready_o, result_o);
        end
        rst     = 1'b0;
        start_i = 1'b0;
        @(posedge clk); #1;
        run_req(32'd9, 32'd3, 1'b0, 64'h00000000_00000003, 0, "after_reset");
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        for (int i = 0; i < 8; i++) begin
            a = $urandom;
            case (i % 4)
                0:       b = 32'($urandom_range(1, 1000));
                1:       b = $urandom;
                2:       b = 32'hFFFF_FFFF - 32'($urandom_range(0, 50));
                default: b = (i == 7) ? 32'd0 : 32'($urandom_range(1, 17));
            endcase
            s = 1'($urandom_range(0, 1));
            run_req(a, b, s, model(a, b, s), 0, "random");
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_overflow();
        test_abort(1'b1, "abort_annul");
        test_abort(1'b0, "abort_start_drop");
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/div_seq.md
Name: div_seq

Overview:
- Multi-cycle iterative divider. It is the responder side of the execute stage's divide interface (start / operands / signed flag in; 64-bit result / ready out).
- Executes RISC-V DIV, DIVU, REM and REMU using a 32-step radix-2 restoring algorithm.
- Execute stage holds start high and stalls the pipeline until ready is returned, then drops start.
- Result packing: quotient in [31:0], remainder in [63:32].

Parameters:
- DATA_W, 32, operand width; iteration count equals DATA_W.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- signed_div_i  in  1  1 = signed (DIV/REM), 0 = unsigned (DIVU/REMU); sampled at start.
- opdata1_i  in  DATA_W  dividend; sampled at start.
- opdata2_i  in  DATA_W  divisor; sampled at start.
- start_i  in  1  request; held high by the requester until it sees ready_o.
- annul_i  in  1  flush; cancels any in-flight operation.
- result_o  out  2*DATA_W  {remainder, quotient}; registered.
- ready_o  out  1  result valid; registered.

Behaviour:
- Reset (rst=1 at an edge): state=FREE, counter=0, ready_o=0, result_o=0. Reset mid-operation discards all work.
- States: FREE, BYZERO, ON, END.
- FREE:
  - start_i=1, annul_i=0, divisor!=0: latch operands. If signed, convert each negative operand to its magnitude (two's-complement negate); record the sign of the dividend and the sign of the quotient (XOR of operand signs). Load a 65-bit partial register = {33'b0, |dividend|}, cnt=0, go to ON.
  - start_i=1, annul_i=0, divisor==0: go to BYZERO.
  - Otherwise stay in FREE with ready_o=0.
- BYZERO: result = {opdata1 (original dividend), all-ones quotient}, for both signed and unsigned. Go to END.
- ON, one iteration per cycle:
  - Shift the partial register left by 1.
  - If upper 33 bits >= {1'b0, |divisor|}: subtract, set quotient LSB=1; else quotient LSB=0.
  - cnt increments. After the iteration with cnt=DATA_W-1, apply sign correction and go to END.
  - Sign correction: quotient negated if its recorded sign is negative; remainder negated if the dividend was negative.
  - Overflow case -2^31 / -1 falls out naturally: quotient 0x80000000, remainder 0. No special case.
- ON with annul_i=1 or start_i=0: abort to FREE; ready_o stays 0 and no result is produced.
- END: ready_o=1 and result_o holds the value.
  - While start_i=1 and annul_i=0: remain in END and hold both outputs.
  - On start_i=0 or annul_i=1: go to FREE, clearing ready_o=0 and result_o=0 on that edge.
- Latency, with start sampled in FREE at edge T:
  - Normal divide: ready_o high from T+DATA_W+1 (33 cycles for DATA_W=32).
  - Divide by zero: ready_o high from T+2.
- ready_o is never high outside END. ready_o is a single registered pulse if the requester drops start_i in the cycle it sees ready_o; the execute stage does this combinationally.
- No back-to-back acceptance: after END the block returns to FREE for at least one cycle before a new start is sampled.
- Operand or sign changes on the inputs while in ON or END are ignored (latched copies only).
- annul_i has priority over start_i in every state.

Test Plan:
- Unsigned 100 / 7 (signed_div_i=0), start held until ready -> ready_o at T+33, result_o=0x00000002_0000000E; ready_o falls the cycle after start_i drops.
- Signed -7 / 2 (0xFFFFFFF9, 0x00000002) -> result_o=0xFFFFFFFF_FFFFFFFD; signed 7 / -2 -> 0x00000001_FFFFFFFD.
- Divide by zero, 5 / 0 in both signed and unsigned modes -> ready_o at T+2, result_o=0x00000005_FFFFFFFF.
- Signed overflow 0x80000000 / 0xFFFFFFFF -> result_o=0x00000000_80000000. Also unsigned 0xFFFFFFFF / 1 -> 0x00000000_FFFFFFFF.
- Abort paths:
  - annul_i pulsed at cycle T+10 -> ready_o never rises, state returns to FREE.
  - Dropping start_i mid-ON -> same abort.
  - A following 9/3 request completes with 0x00000000_00000003 at its own T+33.
- rst asserted at T+15 mid-divide -> next edge ready_o=0, result_o=0. A new request after rst deasserts completes normally with correct latency.
